hex_display_scheduler: RTL
==========================

Name: hex_display_scheduler

Overview:
Time-shares the four DE10-Lite seven-segment displays (HEX0..HEX3) between NUM_REQ requesters. Each requester presents a 16-bit value; the block grants the display to one requester at a time, holds it for a minimum dwell, and rotates round-robin among pending requesters. It sits between the application datapaths and the top-level HEX pins and owns all segment encoding, which is active-low with the decimal point off.

Parameters:
NUM_REQ, 2, number of requesters, legal range 2..4.
DWELL, 50_000_000, minimum cycles an owner keeps the display before it can be pre-empted by a pending requester; 1 s at 50 MHz; legal minimum 2.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
req  input  NUM_REQ  req[i]=1 means requester i wants the display; level, held while wanted.
value  input  16*NUM_REQ  value[16*i+15:16*i] is requester i's four hex digits.
grant  output  NUM_REQ  one-hot or zero; current owner.
HEX0  output  8  active-low segments {dp,g..a}, digit value[3:0] of owner.
HEX1  output  8  digit value[7:4].
HEX2  output  8  digit value[11:8].
HEX3  output  8  digit value[15:12].
LEDR  output  10  LEDR[NUM_REQ-1:0]=grant; the remaining bits are 0.

Behaviour:
- Reset (sync, active-high): state=IDLE, grant=0, ptr=0, dwell counter=0, HEX0..3=8'hFF (blank), LEDR=0. Reset mid-ownership drops the grant on that edge.
- All outputs are registered. grant and HEX update on the same edge. HEX always encodes the value of the requester granted after that edge, sampled at that edge, so there is 1-cycle latency from value to HEX.
- Round-robin pick: search indices ptr, ptr+1, .. mod NUM_REQ and take the first with req set. On every new grant to index k, ptr <= (k+1) mod NUM_REQ.
- IDLE state:
  - no req: stay in IDLE, HEX blank.
  - any req: grant the pick, clear the counter, go to SHOW.
- SHOW state (owner o):
  - The counter increments each cycle and saturates at DWELL-1.
  - req[o]=0: release on this edge. If another req is set, grant the pick immediately (counter cleared, stay in SHOW). Otherwise go to IDLE with grant=0 and HEX blank.
  - req[o]=1, counter==DWELL-1, another req set: switch to the pick (which excludes o whenever others are pending) and clear the counter.
  - req[o]=1, counter==DWELL-1, no other req: keep o; the counter stays saturated.
  - Otherwise, keep o. HEX tracks value of o every cycle.
- A grant is never given to a requester whose req is 0 at that edge. Simultaneous requests are resolved by ptr only.
- Segment code (active low, dp=1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Counter width is clog2(DWELL). The counter has no wrap-around.

Decomposition:
- Shared package seg7_pkg holds:
  - state enum {IDLE, SHOW}
  - SEG_BLANK = 8'hFF
  - 16-entry segment constant table
- Sub-module hex_to_seg7 (4-bit in, 8-bit active-low out, combinational) is instantiated four times. Arbitration, counter and output registers stay in hex_display_scheduler.

Test Plan (NUM_REQ=2, DWELL=4):
1. Reset asserted for 2 cycles with req=2'b11 -> grant=0, HEX0..3=FF, LEDR=0 throughout. On the first edge after release, grant=01 (ptr=0).
2. Only req[0] set, value0=16'h12AF -> one edge later grant=01, HEX3..HEX0=F9,A4,88,8E. This persists indefinitely because there is no competitor.
3. req=11 from IDLE, value0=16'h0000, value1=16'h7777 -> grant=01 for exactly 4 cycles, then 10 for 4, then 01. HEX alternates all C0 / all F8 on the same edges.
4. Owner 0 drops req[0] after 1 cycle while req[1]=1 -> grant=10 on the next edge (no dwell wait). Owner 1 then drops with req[0]=0 -> grant=0 and HEX=FF next edge.
5. Owner 0 with value0 changing 16'h0001->16'h0002 mid-grant -> HEX0 goes F9->A4 exactly one edge after the change; grant unchanged.
6. Reset pulsed while grant=10 mid-dwell -> grant=0 and HEX blank on that edge. With req=11 after release, grant=01 (ptr reset to 0).

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display scheduler:
// scheduler states, the blank pattern and the hex-to-segment table.
package seg7_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    // Active-low segments {dp,g,f,e,d,c,b,a}; all ones turns every segment off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Digit 0..F, decimal point held off (bit 7 = 1).
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83,
        8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to active-low seven-segment pattern.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/hex_display_scheduler.sv
// Shares HEX0..HEX3 between NUM_REQ requesters. Ownership is granted
// round-robin; an owner keeps the display for at least DWELL cycles unless
// it drops its request. All outputs are registered; HEX shows the owner's
// value as sampled on the edge that (re)selects it.
module hex_display_scheduler
    import seg7_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DWELL   = 50_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  value,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             HEX0,
    output logic [7:0]             HEX1,
    output logic [7:0]             HEX2,
    output logic [7:0]             HEX3,
    output logic [9:0]             LEDR
);

    localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;

    logic [NUM_REQ-1:0] others;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   own_idx;
    logic               held;
    logic               expired;
    logic               take_new;
    logic               keep;
    logic               nxt_active;
    logic [IDX_W-1:0]   nxt_idx;
    logic [IDX_W-1:0]   nxt_ptr;
    logic [NUM_REQ-1:0] nxt_grant;
    logic [15:0]        nxt_val;
    logic [7:0]         seg0;
    logic [7:0]         seg1;
    logic [7:0]         seg2;
    logic [7:0]         seg3;

    // Round-robin search from ptr over requesters other than the current
    // owner; in IDLE grant is zero so every requester is a candidate.
    always_comb begin
        others     = req & ~grant;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int s = 0; s < NUM_REQ; s++) begin
            if (!pick_found && others[(int'(ptr) + s) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'((int'(ptr) + s) % NUM_REQ);
            end
        end
        nxt_ptr = IDX_W'((int'(pick_idx) + 1) % NUM_REQ);
    end

    // Index of the current owner, plus whether it still wants the display.
    always_comb begin
        own_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                own_idx = IDX_W'(i);
            end
        end
        held    = |(req & grant);
        expired = (cnt == CNT_MAX);
    end

    // Ownership decision: hand over on release or on dwell expiry with a
    // competitor pending, otherwise keep the current owner (or stay idle).
    always_comb begin
        take_new = 1'b0;
        keep     = 1'b0;
        if (state == SHOW) begin
            if (!held) begin
                take_new = pick_found;
            end else if (expired && pick_found) begin
                take_new = 1'b1;
            end else begin
                keep = 1'b1;
            end
        end else begin
            take_new = pick_found;
        end
        nxt_active = take_new | keep;
        nxt_idx    = take_new ? pick_idx : own_idx;
        nxt_grant  = nxt_active ? (NUM_REQ'(1) << nxt_idx) : '0;
    end

    // Select the value of whoever owns the display after this edge.
    always_comb begin
        nxt_val = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(nxt_idx) == i) begin
                nxt_val = value[16*i +: 16];
            end
        end
    end

    hex_to_seg7 u_seg0 (.digit(nxt_val[3:0]),   .seg(seg0));
    hex_to_seg7 u_seg1 (.digit(nxt_val[7:4]),   .seg(seg1));
    hex_to_seg7 u_seg2 (.digit(nxt_val[11:8]),  .seg(seg2));
    hex_to_seg7 u_seg3 (.digit(nxt_val[15:12]), .seg(seg3));

    // Register state, grant, pointer, dwell counter and all display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
            cnt   <= '0;
            HEX0  <= SEG_BLANK;
            HEX1  <= SEG_BLANK;
            HEX2  <= SEG_BLANK;
            HEX3  <= SEG_BLANK;
            LEDR  <= '0;
        end else begin
            state <= nxt_active ? SHOW : IDLE;
            grant <= nxt_grant;
            if (take_new) begin
                ptr <= nxt_ptr;
            end
            // Counter restarts on every new owner and saturates otherwise.
            if (take_new || !nxt_active) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            HEX0 <= nxt_active ? seg0 : SEG_BLANK;
            HEX1 <= nxt_active ? seg1 : SEG_BLANK;
            HEX2 <= nxt_active ? seg2 : SEG_BLANK;
            HEX3 <= nxt_active ? seg3 : SEG_BLANK;
            LEDR <= {{(10-NUM_REQ){1'b0}}, nxt_grant};
        end
    end

endmodule
